// File: rtl/bridge_rst_seq.sv
// bridge_rst_seq: power-up/recovery reset sequencer for the CSI-2/DSI bridge
module bridge_rst_seq #(
  parameter int LOCK_SETTLE = 64,
  parameter int DPHY_WAIT   = 32,
  parameter int STAGE_GAP   = 8,
  parameter int WDOG_CYC    = 1048576,
  parameter int CNT_W       = 21
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       pll_lock_i,
  input  logic       act_toggle_i,
  output logic       pd_dphy_o,
  output logic       reset_n_o,
  output logic       reset_lp_n_o,
  output logic       reset_byte_n_o,
  output logic       reset_byte_fr_n_o,
  output logic       reset_pixel_n_o,
  output logic       ready_o,
  output logic [2:0] state_o,
  output logic [7:0] restart_cnt_o
);
  typedef enum logic [2:0] {PD, WAIT_LOCK, SETTLE, REL_DPHY, REL_BYTE, RUN} state_t;
  localparam logic [CNT_W-1:0] L_SET  = CNT_W'(LOCK_SETTLE - 1);
  localparam logic [CNT_W-1:0] L_DPHY = CNT_W'(DPHY_WAIT - 1);
  localparam logic [CNT_W-1:0] L_GAP  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] L_WDOG = CNT_W'(WDOG_CYC - 1);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [1:0]       r_lock_s;
  logic [2:0]       r_act_s;
  logic             r_pd, r_dphy_n, r_byte_n, r_pix_n;
  logic [7:0]       r_restarts;
  logic             w_lock, w_act, w_wdog, w_inc;
  assign w_lock = r_lock_s[1];
  assign w_act  = r_act_s[1] ^ r_act_s[2];
  assign w_wdog = (WDOG_CYC != 0) && !w_act && r_cnt == L_WDOG;
  always_comb begin
    w_next = r_state;
    case (r_state)
      PD:        w_next = WAIT_LOCK;
      WAIT_LOCK: w_next = w_lock ? SETTLE : WAIT_LOCK;
      SETTLE:    w_next = !w_lock ? WAIT_LOCK : r_cnt == L_SET ? REL_DPHY : SETTLE;
      REL_DPHY:  w_next = !w_lock ? PD : r_cnt == L_DPHY ? REL_BYTE : REL_DPHY;
      REL_BYTE:  w_next = !w_lock ? PD : r_cnt == L_GAP ? RUN : REL_BYTE;
      RUN:       w_next = (!w_lock || w_wdog) ? PD : RUN;
      default:   w_next = PD;
    endcase
    w_inc = r_state == RUN && w_next == PD;
    // idle states and an activity pulse in RUN keep the counter at zero; no watchdog means no counting
    w_cnt = (w_next != r_state || r_state == PD || r_state == WAIT_LOCK || (r_state == RUN && w_act)) ? '0 :
            (r_state == RUN && WDOG_CYC == 0) ? r_cnt : r_cnt + 1'b1;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= PD;
      r_cnt      <= '0;
      r_lock_s   <= '0;
      r_act_s    <= '0;
      r_pd       <= 1'b1;
      r_dphy_n   <= 1'b0;
      r_byte_n   <= 1'b0;
      r_pix_n    <= 1'b0;
      r_restarts <= '0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt;
      r_lock_s   <= {r_lock_s[0], pll_lock_i};
      r_act_s    <= {r_act_s[1:0], act_toggle_i};
      r_pd       <= w_next < REL_DPHY;
      r_dphy_n   <= w_next >= REL_DPHY;
      r_byte_n   <= w_next >= REL_BYTE;
      r_pix_n    <= w_next == RUN;
      r_restarts <= (w_inc && r_restarts != 8'hFF) ? r_restarts + 8'd1 : r_restarts;
    end
  end
  assign pd_dphy_o         = r_pd;
  assign reset_n_o         = r_dphy_n;
  assign reset_lp_n_o      = r_dphy_n;
  assign reset_byte_n_o    = r_byte_n;
  assign reset_byte_fr_n_o = r_byte_n;
  assign reset_pixel_n_o   = r_pix_n;
  assign ready_o           = r_pix_n;
  assign state_o           = r_state;
  assign restart_cnt_o     = r_restarts;
endmodule

// File: tb/tb_bridge_rst_seq.sv
// tb_bridge_rst_seq: directed bench for the bridge reset sequencer
module tb_bridge_rst_seq;
  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       pll_lock_i = 1'b0;
  logic       act_toggle_i = 1'b0;
  logic       pd_dphy_o, reset_n_o, reset_lp_n_o, reset_byte_n_o, reset_byte_fr_n_o, reset_pixel_n_o, ready_o;
  logic [2:0] state_o;
  logic [7:0] restart_cnt_o;
  int total = 0;
  int bad = 0;
  int n;
  int timeouts = 0;
  bridge_rst_seq #(.WDOG_CYC(1000)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .pll_lock_i(pll_lock_i), .act_toggle_i(act_toggle_i),
    .pd_dphy_o(pd_dphy_o), .reset_n_o(reset_n_o), .reset_lp_n_o(reset_lp_n_o),
    .reset_byte_n_o(reset_byte_n_o), .reset_byte_fr_n_o(reset_byte_fr_n_o),
    .reset_pixel_n_o(reset_pixel_n_o), .ready_o(ready_o), .state_o(state_o),
    .restart_cnt_o(restart_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick(input int k);
    repeat (k) @(posedge clk_i);
    #1;
  endtask
  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // packed view: {pd, rst_n, lp_n, byte_n, byte_fr_n, pix_n, ready}
  function automatic int outs();
    return int'({pd_dphy_o, reset_n_o, reset_lp_n_o, reset_byte_n_o, reset_byte_fr_n_o, reset_pixel_n_o, ready_o});
  endfunction
  task automatic wait_state(input int s, input int lim, input string tag);
    int k = 0;
    while (int'(state_o) != s && k < lim) begin
      tick(1);
      k++;
    end
    check(tag, int'(state_o), s);
  endtask
  initial begin
    tick(2);
    check("rst_state", int'(state_o), 0);
    check("rst_outs", outs(), 7'b1000000);
    check("rst_restarts", int'(restart_cnt_o), 0);
    reset_i = 1'b0;
    tick(5);
    check("no_lock_wait", int'(state_o), 1);
    pll_lock_i = 1'b1;
    tick(20);
    check("settle_entered", int'(state_o), 2);
    pll_lock_i = 1'b0;
    tick(4);
    check("settle_abort_state", int'(state_o), 1);
    check("settle_abort_outs", outs(), 7'b1000000);
    check("settle_abort_restarts", int'(restart_cnt_o), 0);
    reset_i = 1'b1;
    pll_lock_i = 1'b1;
    tick(2);
    reset_i = 1'b0;
    n = 0;
    while (!reset_n_o && n < 200) begin
      tick(1);
      n++;
    end
    check("dphy_release_cycles", n, 67);
    check("rel_dphy_state", int'(state_o), 3);
    check("rel_dphy_outs", outs(), 7'b0110000);
    tick(31);
    check("rel_dphy_hold", outs(), 7'b0110000);
    tick(1);
    check("rel_byte_state", int'(state_o), 4);
    check("rel_byte_outs", outs(), 7'b0111100);
    tick(7);
    check("rel_byte_hold", int'(state_o), 4);
    tick(1);
    check("run_state", int'(state_o), 5);
    check("run_outs", outs(), 7'b0111111);
    pll_lock_i = 1'b0;
    tick(2);
    check("lock_loss_sync_delay", int'(state_o), 5);
    tick(1);
    check("lock_loss_state", int'(state_o), 0);
    check("lock_loss_outs", outs(), 7'b1000000);
    check("lock_loss_restarts", int'(restart_cnt_o), 1);
    pll_lock_i = 1'b1;
    wait_state(3, 200, "resequence_rel_dphy");
    pll_lock_i = 1'b0;
    tick(3);
    check("dphy_drop_state", int'(state_o), 0);
    check("dphy_drop_no_count", int'(restart_cnt_o), 1);
    pll_lock_i = 1'b1;
    wait_state(5, 300, "resequence_run");
    for (int i = 0; i < 3; i++) begin
      tick(499);
      act_toggle_i = ~act_toggle_i;
      check("wdog_fed", int'(state_o), 5);
    end
    tick(499);
    act_toggle_i = ~act_toggle_i;
    tick(1002);
    check("wdog_edge_hold", int'(state_o), 5);
    tick(1);
    check("wdog_expire_state", int'(state_o), 0);
    check("wdog_expire_restarts", int'(restart_cnt_o), 2);
    for (int i = 0; i < 300; i++) begin
      n = 0;
      while (state_o != 3'd5 && n < 300) begin
        tick(1);
        n++;
      end
      if (n >= 300) timeouts++;
      pll_lock_i = 1'b0;
      tick(3);
      pll_lock_i = 1'b1;
      if (i == 252) check("restarts_reach_255", int'(restart_cnt_o), 255);
    end
    check("saturate_timeouts", timeouts, 0);
    check("restarts_saturated", int'(restart_cnt_o), 255);
    wait_state(4, 300, "reach_rel_byte");
    tick(3);
    #2 reset_i = 1'b1;
    #1;
    check("async_rst_state", int'(state_o), 0);
    check("async_rst_outs", outs(), 7'b1000000);
    check("async_rst_restarts", int'(restart_cnt_o), 0);
    tick(2);
    reset_i = 1'b0;
    tick(1);
    check("post_rst_wait_lock", int'(state_o), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
